mult_seq_2bit: RTL and testbench

Sequential unsigned WIDTH×WIDTH multiplier built on `Multiplier_2x2` tiles, one stage downstream of the 2×2 tile in the systolic-array datapath. On each cycle it multiplies one 2-bit digit of B against every 2-bit digit of A using WIDTH/2 `Multiplier_2x2` instances. It shifts and sums those partial products into a 2·WIDTH accumulator. A start/done handshake frames each multiplication. The APPROX parameter is passed through to every tile, which selects an exact or an approximate product.

---
 rtl/mult_seq_2bit.sv | 139 +++++++++++++
 tb/tb_mult_seq_2bit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_2bit.sv
// Sequential unsigned WIDTH x WIDTH multiplier built from 2x2 tiles.
// Each CALC cycle multiplies one 2-bit digit of B against all digits of A,
// shifts the partial product into place and accumulates it.

// 2x2 digit multiplier tile; APPROX=1 maps 3x3 to 7 instead of 9.
module Multiplier_2x2 #(
    parameter int APPROX = 0
) (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    // Exact product, or the approximate 3x3 -> 7 substitution.
    always_comb begin
        if (APPROX != 0 && a == 2'b11 && b == 2'b11) begin
            p = 4'd7;
        end else begin
            p = {2'b00, a} * {2'b00, b};
        end
    end

endmodule

module mult_seq_2bit #(
    parameter int WIDTH  = 8,
    parameter int APPROX = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   OUT
);

    localparam int NDIG = WIDTH / 2;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = WIDTH + 2;
    localparam int OW   = 2 * WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("mult_seq_2bit: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OW-1:0]    acc;
    logic [KW-1:0]    k;

    logic [1:0]       b_dig;
    logic [3:0]       tile_p [NDIG];
    logic [PW-1:0]    p_sum;
    logic [OW-1:0]    acc_next;

    // Select the current multiplier digit b_q[2k+1:2k].
    always_comb begin
        b_dig = 2'(b_q >> {k, 1'b0});
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_tile
            Multiplier_2x2 #(.APPROX(APPROX)) u_tile (
                .a (a_q[2*gi +: 2]),
                .b (b_dig),
                .p (tile_p[gi])
            );
        end
    endgenerate

    // Partial product: tile outputs shifted by their A-digit position.
    always_comb begin
        p_sum = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            p_sum = p_sum + (PW'(tile_p[i]) << (2 * i));
        end
    end

    // Accumulator update with the partial product aligned to digit k of B.
    always_comb begin
        acc_next = acc + (OW'(p_sum) << {k, 1'b0});
    end

    // Control FSM and datapath registers; FIN accepts START like IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            k     <= '0;
            OUT   <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        a_q   <= A;
                        b_q   <= B;
                        acc   <= '0;
                        k     <= '0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        OUT   <= acc_next;
                        state <= FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decoded from the registered state only.
    always_comb begin
        BUSY = (state == CALC);
        DONE = (state == FIN);
    end

endmodule

// File: tb/tb_mult_seq_2bit.sv
// Scoreboard bench for mult_seq_2bit: three instances (W8 exact, W4 exact,
// W8 approximate) driven with random and directed operands.
module tb_mult_seq_2bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s8, s4, sa;
    logic [7:0]  a8, b8, aa, ba;
    logic [3:0]  a4, b4;
    logic        busy8, done8, busy4, done4, busya, donea;
    logic [15:0] out8, outa;
    logic [7:0]  out4;

    mult_seq_2bit #(.WIDTH(8), .APPROX(0)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(s8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .OUT(out8)
    );
    mult_seq_2bit #(.WIDTH(4), .APPROX(0)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(s4), .A(a4), .B(b4),
        .BUSY(busy4), .DONE(done4), .OUT(out4)
    );
    mult_seq_2bit #(.WIDTH(8), .APPROX(1)) duta (
        .CLK(clk), .RST_N(rst_n), .START(sa), .A(aa), .B(ba),
        .BUSY(busya), .DONE(donea), .OUT(outa)
    );

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        longint v;
        longint c;
    } exp_t;

    exp_t   sbq [3][$];
    longint last_exp [3];

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain product, or digit-wise sum with 3x3 counted as 7.
    function automatic longint model(int d, int a, int b);
        longint s = 0;
        if (d != 2) return longint'(a) * longint'(b);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                int x = (a >> (2 * i)) & 3;
                int y = (b >> (2 * k)) & 3;
                int t = (x == 3 && y == 3) ? 7 : x * y;
                s += longint'(t) << (2 * (i + k));
            end
        end
        return s & 64'hFFFF;
    endfunction

    function automatic int lat(int d);
        return (d == 1) ? 2 : 4;
    endfunction

    function automatic longint out_of(int d);
        case (d)
            0:       return longint'(out8);
            1:       return longint'(out4);
            default: return longint'(outa);
        endcase
    endfunction

    function automatic logic busy_of(int d);
        case (d)
            0:       return busy8;
            1:       return busy4;
            default: return busya;
        endcase
    endfunction

    function automatic logic done_of(int d);
        case (d)
            0:       return done8;
            1:       return done4;
            default: return donea;
        endcase
    endfunction

    task automatic set_in(int d, int a, int b, logic s);
        case (d)
            0:       begin a8 = 8'(a); b8 = 8'(b); s8 = s; end
            1:       begin a4 = 4'(a); b4 = 4'(b); s4 = s; end
            default: begin aa = 8'(a); ba = 8'(b); sa = s; end
        endcase
    endtask

    // Called shortly after a rising edge while the DUT is IDLE or FIN.
    // During CALC, operands and START are scrambled; the result must not change.
    task automatic issue(int d, int a, int b);
        int   l = lat(d);
        int   m = (d == 1) ? 15 : 255;
        exp_t e;
        a = a & m;
        b = b & m;
        set_in(d, a, b, 1'b1);
        @(posedge clk); #1;
        e.v = model(d, a, b);
        e.c = cyc + l;
        sbq[d].push_back(e);
        last_exp[d] = e.v;
        chk($sformatf("busy_after_accept_dut%0d", d), longint'(busy_of(d)), 1);
        for (int j = 0; j < l; j++) begin
            set_in(d, int'($urandom), int'($urandom), 1'($urandom));
            @(posedge clk); #1;
        end
        chk($sformatf("done_at_finish_dut%0d", d), longint'(done_of(d)), 1);
        chk($sformatf("busy_at_finish_dut%0d", d), longint'(busy_of(d)), 0);
    endtask

    task automatic idle(int d, int n);
        set_in(d, int'($urandom), int'($urandom), 1'b0);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    task automatic mon_step(int d);
        exp_t e;
        if (!rst_n) return;
        if (done_of(d)) begin
            if (sbq[d].size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done_dut%0d: got DONE=1 required DONE=0 at cycle %0d", d, cyc);
            end else begin
                e = sbq[d].pop_front();
                chk($sformatf("out_dut%0d", d), out_of(d), e.v);
                chk($sformatf("done_cycle_dut%0d", d), cyc, e.c);
            end
        end else if (sbq[d].size() > 0 && cyc > sbq[d][0].c) begin
            e = sbq[d].pop_front();
            n_chk++;
            $display("FAIL missing_done_dut%0d: no DONE by cycle %0d (now %0d)", d, e.c, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon_step(d);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 0, 0, 1'b0);
            last_exp[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out_dut%0d", d), out_of(d), 0);
            chk($sformatf("reset_busy_dut%0d", d), longint'(busy_of(d)), 0);
            chk($sformatf("reset_done_dut%0d", d), longint'(done_of(d)), 0);
        end
        rst_n = 1'b1;

        // W8 exact corners, first one on the first edge after release
        issue(0, 0, 255);
        idle(0, 1);
        issue(0, 255, 255);
        issue(0, 1, 1);
        issue(0, 170, 85);
        idle(0, 2);
        repeat (30) begin
            issue(0, int'($urandom), int'($urandom));
            idle(0, $urandom_range(0, 2));
        end

        // Back-to-back with START held across FIN
        repeat (5) issue(0, int'($urandom), int'($urandom));
        issue(0, 170, 85);

        // Hold: OUT stable and flags low while idle
        set_in(0, int'($urandom), int'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_out", longint'(out8), last_exp[0]);
            chk("hold_busy", longint'(busy8), 0);
            chk("hold_done", longint'(done8), 0);
        end

        // Reset during the second CALC cycle of 200 x 150
        set_in(0, 200, 150, 1'b1);
        @(posedge clk); #1;
        set_in(0, 200, 150, 1'b0);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_out", longint'(out8), 0);
        chk("midrun_reset_busy", longint'(busy8), 0);
        chk("midrun_reset_done", longint'(done8), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 8);
        chk("after_reset_out", longint'(out8), 0);

        // W4 exact exhaustive
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(1, a, b);
                if ($urandom_range(0, 2) != 0) idle(1, $urandom_range(1, 2));
            end
        end
        idle(1, 1);

        // W8 approximate
        issue(2, 255, 255);
        idle(2, 1);
        issue(2, 2, 3);
        idle(2, 1);
        repeat (20) begin
            issue(2, int'($urandom), int'($urandom));
            idle(2, $urandom_range(0, 1));
        end
        idle(2, 1);

        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("queue_drained_dut%0d", d), longint'(sbq[d].size()), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
